// File: rtl/sha256_pkg.sv
// Shared types, sizes and message-schedule sigma functions for the SHA-256 schedule sequencer.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  localparam int WIN_DEPTH  = 16;
  localparam int MAX_ROUNDS = 64;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/msg_sched_sigma.sv
// Next schedule word from the current window taps: W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
module msg_sched_sigma
  import sha256_pkg::*;
(
  input  word_t w0,
  input  word_t w1,
  input  word_t w9,
  input  word_t w14,
  output word_t w_next
);

  assign w_next = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/msg_sched_seq.sv
// SHA-256 message schedule sequencer: loads 16 message words, then streams W[0..ROUNDS-1]
// from a shifting 16-word window.
module msg_sched_seq
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64,
  parameter int W      = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_m_valid,
  input  logic [W-1:0] i_m_word,
  output logic         o_m_ready,
  output logic         o_w_valid,
  output logic [W-1:0] o_w_word,
  output logic [5:0]   o_w_idx,
  output logic         o_w_last,
  input  logic         i_w_ready,
  output logic         o_busy,
  output logic [1:0]   o_dbg_state
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] LOAD = ST_LOAD;
  localparam logic [1:0] EMIT = ST_EMIT;

  localparam logic [5:0] T_LAST   = (ROUNDS > MAX_ROUNDS) ? 6'(MAX_ROUNDS - 1) : 6'(ROUNDS - 1);
  localparam logic [3:0] LOAD_TOP = 4'(WIN_DEPTH - 1);

  logic [1:0]   state;
  logic [3:0]   load_cnt;
  logic [5:0]   t;
  logic [W-1:0] win [WIN_DEPTH];
  logic [W-1:0] w_next;
  logic         m_acc;
  logic         w_acc;

  // Handshakes: a word moves only on a cycle where its valid and ready are both high.
  // Input side (m) and output side (w) are independent; ready never depends on valid.
  assign m_acc = i_m_valid && o_m_ready;
  assign w_acc = o_w_valid && i_w_ready;

  msg_sched_sigma u_sigma (
    .w0     (win[0]),
    .w1     (win[1]),
    .w9     (win[9]),
    .w14    (win[14]),
    .w_next (w_next)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      load_cnt <= '0;
      t        <= '0;
      for (int i = 0; i < WIN_DEPTH; i++) win[i] <= '0;
    end else if (i_clear) begin
      state    <= IDLE;
      load_cnt <= '0;
      t        <= '0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (m_acc) begin
            win[load_cnt] <= i_m_word;
            load_cnt      <= load_cnt + 4'd1;
            if (load_cnt == LOAD_TOP) begin
              state <= EMIT;
              t     <= '0;
            end else begin
              state <= LOAD;
            end
          end
        end
        EMIT: begin
          if (w_acc) begin
            for (int i = 0; i < WIN_DEPTH - 1; i++) win[i] <= win[i+1];
            win[WIN_DEPTH-1] <= w_next;
            if (t == T_LAST) begin
              state <= IDLE;
              t     <= '0;
            end else begin
              t <= t + 6'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs come straight from registers, so i_w_ready never reaches o_w_word combinationally.
  assign o_m_ready   = i_rst_n && (state != EMIT);
  assign o_w_valid   = (state == EMIT);
  assign o_w_word    = win[0];
  assign o_w_idx     = t;
  assign o_w_last    = o_w_valid && (t == T_LAST);
  assign o_busy      = (state != IDLE);
  assign o_dbg_state = state;

endmodule

// File: doc/msg_sched_seq.md
MSG_SCHED_SEQ -- requirements
Module: msg_sched_seq

Interface
REQ-001 Parameter ROUNDS, default 64: number of schedule words emitted per block; legal range 16..64.
REQ-002 Parameter W, default 32: word width; only 32 is supported.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, synchronous and active-low.
REQ-005 i_clear  input  1  synchronous abort; returns the block to IDLE.
REQ-006 i_m_valid  input  1  message word valid.
REQ-007 i_m_word  input  32  message word M[j], big-endian word order, j=0..15.
REQ-008 o_m_ready  output  1  block accepts a message word this cycle.
REQ-009 o_w_valid  output  1  schedule word valid.
REQ-010 o_w_word  output  32  schedule word W[t].
REQ-011 o_w_idx  output  6  t of the word on o_w_word.
REQ-012 o_w_last  output  1  high with the word where t = ROUNDS-1.
REQ-013 i_w_ready  input  1  consumer accepts W[t] this cycle.
REQ-014 o_busy  output  1  high in LOAD or EMIT.

Function
REQ-015 FSM states: IDLE, LOAD, EMIT.
- IDLE: o_m_ready=1; the first accepted word starts LOAD.
- LOAD: o_m_ready=1 until 16 words are held.
- EMIT: o_m_ready=0.
REQ-016 A transfer occurs only on a cycle where valid and ready are both high; the input and output handshakes are independent.
REQ-017 Words are held in a 16-entry window, win[0..15]; an accepted input word is written at win[load_cnt], and load_cnt increments 0..15.
REQ-018 Acceptance of the 16th word moves the FSM to EMIT on the next cycle, with t=0 and o_w_valid=1 that cycle; input-to-first-output latency is 1 cycle.
REQ-019 In EMIT: o_w_word=win[0], o_w_idx=t, and o_w_valid stays high until the transfer.
REQ-020 On each output transfer:
- the window shifts down by one;
- win[15] <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], modulo 2^32;
- t increments.
REQ-021 sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10; all additions wrap, with no carry out.
REQ-022 When i_w_ready=0, the window, t and all outputs hold stable; there is no combinational path from i_w_ready to o_w_word.
REQ-023 Transfer of t=ROUNDS-1 returns the FSM to IDLE; o_m_ready rises on the next cycle, so there are no back-to-back block overlaps.
REQ-024 Input words presented while o_m_ready=0 are ignored, not captured.
REQ-025 i_clear is honoured in any state and has priority over both handshakes that cycle.
- Next cycle the block is in IDLE, load_cnt=0, t=0, o_w_valid=0.
- A partially loaded or partially emitted block is discarded.
REQ-026 A simultaneous i_clear and 16th input word: the clear wins and the word is discarded.
REQ-027 A simultaneous final output transfer and i_m_valid: the word is not accepted that cycle.

Reset
REQ-028 While i_rst_n=0 at a clock edge, the next state is:
- FSM=IDLE, load_cnt=0, t=0;
- o_w_valid=0, o_w_last=0, o_busy=0, o_w_idx=0, o_w_word=0;
- o_m_ready=0 during reset, and 1 from the first cycle after release.
REQ-029 Window contents are reset to zero.
REQ-030 Reset mid-operation behaves as i_clear.

Structure
REQ-031 Package sha256_pkg holds:
- word_t (32-bit);
- the state enum;
- the constants 16 (window depth) and 64 (max rounds);
- the sigma0/sigma1 functions.
REQ-032 One combinational sub-module, msg_sched_sigma, computes the next window word from win[0], win[1], win[9] and win[14].
REQ-033 Target size 150-250 RTL lines, excluding the package.

Verification
REQ-034 "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), i_w_ready=1 throughout:
- W16=0x61626380, W17=0x000F0000, W18=0x7DA86405;
- 64 words total, o_w_last only at idx 63.
REQ-035 Same block with i_w_ready toggling on a 1-in-3 pattern: the identical word sequence; o_w_word holds stable while stalled.
REQ-036 i_clear asserted after 8 words loaded, then a full new block loaded: the output matches a fresh-block golden model with no stale words.
REQ-037 i_m_valid held high during EMIT with dummy 0xDEADBEEF: never captured; the next block's W0 equals its own M0.
REQ-038 Reset pulsed at t=30 of EMIT: o_w_valid=0 the next cycle, and the following block emits from idx 0.
REQ-039 ROUNDS=16: exactly M0..M15 emitted, with o_w_last at idx 15.
